// File: rtl/bsg_rr_decode_arb.sv
// bsg_decode: binary index to one-hot vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output simply follows the input.
//   i : binary index, $clog2(num_out_p) bits
//   o : one-hot vector, num_out_p bits (all zero if i >= num_out_p)
module bsg_decode #(
  parameter int num_out_p = 4
) (
  input  logic [$clog2(num_out_p)-1:0] i,
  output logic [num_out_p-1:0]         o
);

  assign o = num_out_p'(1) << i;

endmodule

// bsg_rr_decode_arb: round-robin arbiter with a locked, time-limited grant.
// Latency: grant appears one edge after a request is seen in IDLE; one idle bubble follows each release.
// Backpressure: the grant holder keeps the grant until release_i or the hold limit expires.
//   clk_i           : single clock, rising edge
//   reset_n_i       : asynchronous active-low reset
//   reqs_i          : per-requester request levels (els_p bits)
//   release_i       : holder finished; only looked at while a grant is active
//   grant_v_o       : a grant is active
//   grant_id_o      : binary id of the granted requester (0 when idle)
//   grant_one_hot_o : one-hot grant, zero when grant_v_o=0
//   timeout_o       : one-cycle pulse when the hold limit forced a release
module bsg_rr_decode_arb #(
  parameter  int els_p      = 16,
  parameter  int max_hold_p = 64,
  localparam int lg_els_lp  = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [els_p-1:0]     reqs_i,
  input  logic                 release_i,
  output logic                 grant_v_o,
  output logic [lg_els_lp-1:0] grant_id_o,
  output logic [els_p-1:0]     grant_one_hot_o,
  output logic                 timeout_o
);

  localparam logic [0:0] idle_s  = 1'b0;
  localparam logic [0:0] grant_s = 1'b1;

  // The counter only ever needs to reach max_hold_p-1; a zero limit still
  // gets a one-bit counter that is never compared.
  localparam int hold_w_lp = (max_hold_p > 1) ? $clog2(max_hold_p) : 1;
  localparam logic [hold_w_lp-1:0] hold_last_lp =
    hold_w_lp'((max_hold_p > 0) ? (max_hold_p - 1) : 0);
  localparam logic hold_en_lp = (max_hold_p > 0);

  localparam logic [lg_els_lp-1:0] last_id_lp = lg_els_lp'(els_p - 1);

  logic [0:0]           state_r;
  logic [lg_els_lp-1:0] ptr_r;
  logic [hold_w_lp-1:0] hold_cnt_r;
  logic [lg_els_lp-1:0] grant_id_r;
  logic                 timeout_r;

  logic                 any_req;
  logic                 found;
  int                   cand;
  logic [lg_els_lp-1:0] winner_id;
  logic [lg_els_lp-1:0] ptr_next;
  logic                 hold_expired;
  logic [els_p-1:0]     dec_lo;

  assign any_req = |reqs_i;

  // Rotating priority search: visit ptr_r, ptr_r+1, ... wrapping at els_p,
  // and take the first requester that is asserted. Wrap is done with a
  // compare/subtract so non-power-of-two els_p needs no modulo hardware.
  always_comb begin
    found     = 1'b0;
    cand      = 0;
    winner_id = '0;
    for (int k = 0; k < els_p; k++) begin
      cand = int'(ptr_r) + k;
      if (cand >= els_p) begin
        cand = cand - els_p;
      end
      if (!found && reqs_i[cand]) begin
        found     = 1'b1;
        winner_id = lg_els_lp'(cand);
      end
    end
  end

  // The requester after the winner gets first look next time.
  assign ptr_next = (winner_id == last_id_lp) ? '0 : (winner_id + lg_els_lp'(1));

  assign hold_expired = hold_en_lp && (hold_cnt_r == hold_last_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= idle_s;
      ptr_r      <= '0;
      hold_cnt_r <= '0;
      grant_id_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        idle_s: begin
          // release_i is deliberately not looked at here.
          if (any_req) begin
            state_r    <= grant_s;
            grant_id_r <= winner_id;
            ptr_r      <= ptr_next;
            hold_cnt_r <= '0;
          end
        end
        grant_s: begin
          // Grant is locked: reqs_i has no effect until the grant ends.
          // An explicit release wins over the limit, so no timeout pulse
          // when both happen on the same edge.
          if (release_i) begin
            state_r    <= idle_s;
            grant_id_r <= '0;
            hold_cnt_r <= '0;
          end else if (hold_expired) begin
            state_r    <= idle_s;
            grant_id_r <= '0;
            hold_cnt_r <= '0;
            timeout_r  <= 1'b1;
          end else begin
            // With no limit this may wrap; it is never compared then.
            hold_cnt_r <= hold_cnt_r + hold_w_lp'(1);
          end
        end
        default: begin
          state_r    <= idle_s;
          grant_id_r <= '0;
          hold_cnt_r <= '0;
        end
      endcase
    end
  end

  // All outputs come straight from registers or a decode of them.
  assign grant_v_o  = (state_r == grant_s);
  assign grant_id_o = grant_id_r;
  assign timeout_o  = timeout_r;

  bsg_decode #(
    .num_out_p(els_p)
  ) grant_decode (
    .i(grant_id_r),
    .o(dec_lo)
  );

  assign grant_one_hot_o = dec_lo & {els_p{grant_v_o}};

endmodule

// File: doc/bsg_rr_decode_arb.md
BSG_RR_DECODE_ARB -- requirements
Module: bsg_rr_decode_arb

Interface
REQ-001 SHALL have parameter els_p, default 16: number of requesters; legal range 2..16.
REQ-002 SHALL have parameter max_hold_p, default 64: maximum cycles one grant is held; 0 = unlimited.
REQ-003 SHALL derive lg_els_lp = ceil(log2(els_p)), which is 4 at default.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port reqs_i  input  els_p  per-requester request level.
REQ-007 SHALL have port release_i  input  1  current grant holder finished; sampled only in GRANT.
REQ-008 SHALL have port grant_v_o  output  1  a grant is active.
REQ-009 SHALL have port grant_id_o  output  lg_els_lp  encoded id of the granted requester.
REQ-010 SHALL have port grant_one_hot_o  output  els_p  one-hot grant, zero when grant_v_o=0.
REQ-011 SHALL have port timeout_o  output  1  one-cycle pulse on a forced release.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT; all outputs SHALL be registered or decoded from registers only, with no combinational path from inputs to outputs.
REQ-013 SHALL hold a round-robin pointer ptr_r (lg_els_lp bits) giving the first requester to search.
REQ-014 In IDLE with any reqs_i bit set at edge N, SHALL select the first set bit at index ptr_r, ptr_r+1, ... wrapping from els_p-1 to 0; after edge N: state=GRANT, grant_v_o=1, grant_id_o=winner.
REQ-015 In IDLE with reqs_i=0, SHALL remain in IDLE with all outputs held at 0.
REQ-016 On entry to GRANT, SHALL set ptr_r to winner+1, wrapping to 0 when the winner is els_p-1.
REQ-017 SHALL form grant_one_hot_o by instantiating bsg_decode on grant_id_o, gated with grant_v_o; bits at index >= els_p SHALL be absent.
REQ-018 In GRANT, SHALL keep the grant locked regardless of reqs_i, including when the holder drops its request.
REQ-019 SHALL keep hold_cnt_r at 0 on entry to GRANT and increment it by 1 each GRANT cycle in which no release occurs.
REQ-020 In GRANT with release_i=1 at edge M, SHALL after edge M have state=IDLE and grant_v_o=0; next arbitration is at edge M+1, giving exactly one idle bubble cycle.
REQ-021 With max_hold_p>0, in GRANT with hold_cnt_r==max_hold_p-1 and release_i=0, SHALL force IDLE at that edge and set timeout_o=1 for exactly one cycle.
REQ-022 When release_i and the forced-release condition coincide, SHALL treat it as a normal release with timeout_o=0.
REQ-023 SHALL ignore release_i in IDLE.
REQ-024 SHALL ignore reqs_i bits at index >= els_p.
REQ-025 SHALL size hold_cnt_r to hold max_hold_p-1 without overflow; when max_hold_p=0, the counter SHALL never force a release.

Reset
REQ-026 On reset_n_i=0, SHALL immediately, without waiting for a clock edge, set: state=IDLE, ptr_r=0, hold_cnt_r=0, grant_v_o=0, grant_id_o=0, grant_one_hot_o=0, timeout_o=0.
REQ-027 Reset asserted mid-grant SHALL drop the grant at once; after deassertion, the first arbitration SHALL start its search from requester 0.
REQ-028 SHALL leave no state changed at the first rising edge that coincides with reset_n_i=0.

Verification
REQ-029 Reset release with reqs_i=16'h8001 -> after the next edge: grant_id_o=0, grant_one_hot_o=16'h0001; release, one bubble cycle, then grant_id_o=15, grant_one_hot_o=16'h8000.
REQ-030 All 16 requests held high, release_i pulsed each GRANT cycle -> grants run 0,1,...,15,0 (wraps) with one idle cycle between consecutive grants.
REQ-031 Holder 3 drops its request while granted, release_i=0 -> grant_id_o stays 3; with max_hold_p=64, forced release comes 64 cycles after grant entry: timeout_o=1 for one cycle, then grant_v_o=0.
REQ-032 release_i=1 on the same edge as hold_cnt_r==max_hold_p-1 -> normal release, timeout_o stays 0.
REQ-033 reset_n_i asserted asynchronously mid-grant of requester 9 -> grant_v_o and grant_one_hot_o go 0 without a clock edge; after reset, reqs_i=16'h0600 grants 9 before 10.
REQ-034 els_p=5 with reqs_i=16'hFFE0 -> grant_v_o stays 0 indefinitely.
